multicycle_seq: RTL and testbench

Multi-cycle fetch/decode/execute sequencer for the accumulator CPU. It issues instruction-register load, PC control, accumulator write, ALU opcode and data-memory strobes cycle by cycle. It supports the 10-opcode ISA: CLA, COM, SHR, CSL, STP, ADD, STA, LDA, JMP, BAN. It sits between the instruction register, PC, ALU/accumulator and data memory, and waits on a memory-ready handshake.

---
 rtl/seq_pkg.sv | 40 ++++
 rtl/mem_wait_timer.sv | 38 +++
 rtl/multicycle_seq.sv | 164 ++++++++++++++++
 tb/tb_multicycle_seq.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared opcode map, state encoding and decode helpers for the accumulator
// CPU sequencer and the control-unit decode.
package seq_pkg;

    localparam int OP_W = 7;

    localparam logic [OP_W-1:0] OP_CLA = 7'd0;
    localparam logic [OP_W-1:0] OP_COM = 7'd1;
    localparam logic [OP_W-1:0] OP_SHR = 7'd2;
    localparam logic [OP_W-1:0] OP_CSL = 7'd3;
    localparam logic [OP_W-1:0] OP_STP = 7'd4;
    localparam logic [OP_W-1:0] OP_ADD = 7'd5;
    localparam logic [OP_W-1:0] OP_STA = 7'd6;
    localparam logic [OP_W-1:0] OP_LDA = 7'd7;
    localparam logic [OP_W-1:0] OP_JMP = 7'd8;
    localparam logic [OP_W-1:0] OP_BAN = 7'd9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM_RD,
        ST_MEM_WR,
        ST_HALT
    } state_e;

    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        return op inside {OP_CLA, OP_COM, OP_SHR, OP_CSL};
    endfunction

    function automatic logic is_mem_op(input logic [OP_W-1:0] op);
        return op inside {OP_ADD, OP_STA, OP_LDA};
    endfunction

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return op <= OP_BAN;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts not-ready cycles of a data-memory access; expired flags that the
// current not-ready cycle is the last one allowed before a timeout.
module mem_wait_timer #(
    parameter int TIMEOUT = 15,
    localparam int W = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // clear wins so each access starts from zero
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_seq.sv
// Fetch/decode/execute sequencer for the accumulator CPU: drives IR, PC,
// accumulator, ALU opcode and data-memory strobes with a ready handshake.
module multicycle_seq
    import seq_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [OP_W-1:0] ins,
    input  logic            acc_neg,
    input  logic            mem_ready,
    output logic            ir_load,
    output logic            pc_inc,
    output logic            pc_load,
    output logic            acc_wr_en,
    output logic [OP_W-1:0] alu_op,
    output logic            m_rd_en,
    output logic            m_wr_en,
    output logic            busy,
    output logic            halted,
    output logic            illegal,
    output logic            mem_err,
    output logic [CNT_W-1:0] instr_count
);

    state_e           state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic             illegal_q, illegal_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic in_mem;
    logic wait_cyc;
    logic tmr_expired;
    logic retire;

    assign in_mem   = (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);
    assign wait_cyc = in_mem && !mem_ready;

    mem_wait_timer #(
        .TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q == ST_DECODE),
        .enable (wait_cyc),
        .expired(tmr_expired)
    );

    // next state, opcode capture and sticky error flags
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        mem_err_d = mem_err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                op_d = ins;
                if (!is_legal_op(ins)) begin
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
                end else if (ins == OP_STP) begin
                    state_d = ST_HALT;
                end else if (ins == OP_STA) begin
                    state_d = ST_MEM_WR;
                end else if (is_mem_op(ins)) begin
                    state_d = ST_MEM_RD;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_FETCH;
            ST_MEM_RD, ST_MEM_WR: begin
                // a ready on the last allowed cycle still completes
                if (mem_ready) begin
                    state_d = ST_FETCH;
                end else if (tmr_expired) begin
                    state_d   = ST_HALT;
                    mem_err_d = 1'b1;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // retire count, saturating; STP and illegal never reach FETCH again
    always_comb begin
        retire = (state_d == ST_FETCH) &&
                 (state_q inside {ST_EXEC, ST_MEM_RD, ST_MEM_WR});
        cnt_d  = cnt_q;
        if (retire && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    // state and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            mem_err_q <= mem_err_d;
            cnt_q     <= cnt_d;
        end
    end

    // strobes decoded from state and op_q, ready-cycle work gated by mem_ready
    always_comb begin
        ir_load   = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        acc_wr_en = 1'b0;
        alu_op    = '0;
        m_rd_en   = 1'b0;
        m_wr_en   = 1'b0;
        unique case (state_q)
            ST_FETCH: ir_load = 1'b1;
            ST_EXEC: begin
                if (op_q == OP_JMP) begin
                    pc_load = 1'b1;
                end else if (op_q == OP_BAN) begin
                    pc_load = acc_neg;
                    pc_inc  = !acc_neg;
                end else if (is_alu_op(op_q)) begin
                    acc_wr_en = 1'b1;
                    alu_op    = op_q;
                    pc_inc    = 1'b1;
                end
            end
            ST_MEM_RD: begin
                m_rd_en = 1'b1;
                if (mem_ready) begin
                    acc_wr_en = 1'b1;
                    alu_op    = op_q;
                    pc_inc    = 1'b1;
                end
            end
            ST_MEM_WR: begin
                m_wr_en = 1'b1;
                pc_inc  = mem_ready;
            end
            default: ;
        endcase
    end

    assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted      = (state_q == ST_HALT);
    assign illegal     = illegal_q;
    assign mem_err     = mem_err_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_seq.sv
// Randomized bench for multicycle_seq: an instruction-level model predicts
// every cycle's outputs, a single negedge process compares them.
module tb_multicycle_seq;

    localparam int TMO = 15;
    localparam logic [6:0] B_CLA = 7'd0;
    localparam logic [6:0] B_STP = 7'd4;
    localparam logic [6:0] B_ADD = 7'd5;
    localparam logic [6:0] B_STA = 7'd6;
    localparam logic [6:0] B_LDA = 7'd7;
    localparam logic [6:0] B_JMP = 7'd8;
    localparam logic [6:0] B_BAN = 7'd9;

    logic        clk = 1'b0;
    logic        rst, start, acc_neg, mem_ready;
    logic [6:0]  ins;
    logic        ir_load, pc_inc, pc_load, acc_wr_en;
    logic [6:0]  alu_op;
    logic        m_rd_en, m_wr_en, busy, halted, illegal, mem_err;
    logic [15:0] instr_count;

    multicycle_seq #(.CNT_W(16), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .ins(ins),
        .acc_neg(acc_neg), .mem_ready(mem_ready),
        .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load),
        .acc_wr_en(acc_wr_en), .alu_op(alu_op),
        .m_rd_en(m_rd_en), .m_wr_en(m_wr_en), .busy(busy),
        .halted(halted), .illegal(illegal), .mem_err(mem_err),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ir_load, pc_inc, pc_load, acc_wr_en;
        logic [6:0]  alu_op;
        logic        m_rd_en, m_wr_en, busy, halted, illegal, mem_err;
        logic [15:0] cnt;
    } exp_t;

    exp_t  e;
    bit    e_valid = 0;
    int    checks = 0, errors = 0;
    int    cyc_n = 0;
    int    rd_total = 0, wr_total = 0, rd_mark = 0, wr_mark = 0;
    int    lit_at = -1, lit_kind = 0, lit_exp = 0;
    string lit_name = "";

    int m_count = 0;
    bit m_ill, m_err, m_halt;
    bit pend_ret, pend_halt, pend_ill, pend_err, pend_rst;

    task automatic chk(input string n, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, got, want, $time);
        end
    endtask

    // compare process
    always @(negedge clk) begin
        int got;
        if (e_valid) begin
            chk("ir_load", ir_load, e.ir_load);
            chk("pc_inc", pc_inc, e.pc_inc);
            chk("pc_load", pc_load, e.pc_load);
            chk("acc_wr_en", acc_wr_en, e.acc_wr_en);
            chk("alu_op", alu_op, e.alu_op);
            chk("m_rd_en", m_rd_en, e.m_rd_en);
            chk("m_wr_en", m_wr_en, e.m_wr_en);
            chk("busy", busy, e.busy);
            chk("halted", halted, e.halted);
            chk("illegal", illegal, e.illegal);
            chk("mem_err", mem_err, e.mem_err);
            chk("instr_count", instr_count, e.cnt);
        end
        rd_total += int'(m_rd_en);
        wr_total += int'(m_wr_en);
        if (lit_at == cyc_n) begin
            case (lit_kind)
                0:       got = int'(instr_count);
                1:       got = rd_total - rd_mark;
                default: got = wr_total - wr_mark;
            endcase
            chk(lit_name, got, lit_exp);
        end
    end

    function automatic exp_t base(input bit bsy);
        exp_t x;
        x         = '0;
        x.busy    = bsy;
        x.halted  = m_halt;
        x.illegal = m_ill;
        x.mem_err = m_err;
        x.cnt     = 16'(m_count);
        return x;
    endfunction

    task automatic lit(input int kind, input string n, input int want, input int dly);
        lit_kind = kind;
        lit_name = n;
        lit_exp  = want;
        lit_at   = cyc_n + dly;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
        rst = 1'b0;
        if (pend_rst) begin
            m_count = 0; m_ill = 0; m_err = 0; m_halt = 0;
        end
        if (pend_ret && m_count < 65535) m_count++;
        if (pend_halt) m_halt = 1;
        if (pend_ill) m_ill = 1;
        if (pend_err) m_err = 1;
        {pend_ret, pend_halt, pend_ill, pend_err, pend_rst} = '0;
    endtask

    task automatic bg();
        start     = 1'($urandom);
        mem_ready = 1'($urandom);
        acc_neg   = 1'($urandom);
        ins       = 7'($urandom);
    endtask

    task automatic do_reset();
        cyc(); bg();
        rst = 1'b1;
        e_valid = 0;
        pend_rst = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(); bg(); start = 1'b0;
            e = base(0); e_valid = 1;
        end
    endtask

    task automatic go();
        cyc(); bg(); start = 1'b1;
        e = base(0); e_valid = 1;
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(); bg();
            e = base(0); e_valid = 1;
        end
    endtask

    // one whole instruction, starting at its FETCH cycle
    task automatic run_instr(input logic [6:0] op, input bit neg,
                             input int n_wait, input int abort_at);
        bit is_rd, is_wr;
        is_rd = (op == B_ADD) || (op == B_LDA);
        is_wr = (op == B_STA);
        cyc(); bg();
        e = base(1); e.ir_load = 1; e_valid = 1;
        cyc(); bg(); ins = op;
        e = base(1);
        if (op == B_STP || op > B_BAN) begin
            pend_halt = 1;
            pend_ill  = (op > B_BAN);
        end else if (is_rd || is_wr) begin
            for (int i = 0; i < TMO; i++) begin
                cyc(); bg();
                mem_ready = (i == n_wait);
                e = base(1);
                e.m_rd_en = is_rd;
                e.m_wr_en = is_wr;
                if (i == abort_at) begin
                    mem_ready = 1'b0;
                    rst = 1'b1;
                    pend_rst = 1;
                    break;
                end
                if (mem_ready) begin
                    e.pc_inc = 1;
                    if (is_rd) begin
                        e.acc_wr_en = 1;
                        e.alu_op = op;
                    end
                    pend_ret = 1;
                    break;
                end
                if (i == TMO - 1) begin
                    pend_halt = 1;
                    pend_err  = 1;
                end
            end
        end else begin
            cyc(); bg();
            e = base(1);
            if (op == B_JMP) begin
                e.pc_load = 1;
            end else if (op == B_BAN) begin
                acc_neg   = neg;
                e.pc_load = neg;
                e.pc_inc  = !neg;
            end else begin
                e.acc_wr_en = 1;
                e.alu_op    = op;
                e.pc_inc    = 1;
            end
            pend_ret = 1;
        end
    endtask

    logic [6:0] ops[9] = '{7'd0, 7'd1, 7'd2, 7'd3, 7'd5, 7'd6, 7'd7, 7'd8, 7'd9};

    initial begin
        logic [6:0] op;
        int r, nw;
        rst = 1'b1; start = 0; ins = 0; acc_neg = 0; mem_ready = 0;
        do_reset();
        idle(2);

        go();
        run_instr(B_CLA, 0, 0, -1);
        lit(0, "cla_count", 1, 1);

        rd_mark = rd_total;
        run_instr(B_LDA, 0, 3, -1);
        lit(1, "lda_rd_cycles", 4, 0);

        run_instr(B_BAN, 1, 0, -1);
        run_instr(B_BAN, 0, 0, -1);
        run_instr(B_JMP, 0, 0, -1);
        run_instr(B_ADD, 0, TMO - 1, -1);
        run_instr(B_STA, 0, 0, -1);
        lit(0, "count_before_stp", 7, 1);

        run_instr(B_STP, 0, 0, -1);
        halt_cycles(4);
        do_reset();
        idle(2);

        go();
        run_instr(7'b0001010, 0, 0, -1);
        halt_cycles(3);
        do_reset();
        idle(1);
        go();
        wr_mark = wr_total;
        run_instr(B_STA, 0, 99, -1);
        lit(2, "sta_wr_cycles", TMO, 0);
        halt_cycles(3);
        do_reset();
        idle(1);

        go();
        run_instr(B_CLA, 0, 0, -1);
        run_instr(B_STA, 0, 99, 5);
        idle(2);
        go();
        run_instr(B_CLA, 0, 0, -1);
        lit(0, "count_after_rst", 1, 1);

        for (int t = 0; t < 300; t++) begin
            r = $urandom_range(0, 29);
            if (r == 0) op = B_STP;
            else if (r == 1) op = 7'($urandom_range(10, 127));
            else op = ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 9) == 0) nw = $urandom_range(12, 16);
            else nw = $urandom_range(0, 4);
            run_instr(op, 1'($urandom), nw, -1);
            if (pend_halt) begin
                halt_cycles(2);
                do_reset();
                idle(1);
                go();
            end
        end

        cyc(); bg();
        e_valid = 0;
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
